// File: rtl/alu_op_sequencer_if.sv
// Bundle between the ALU issue sequencer and its surroundings: instruction,
// external register load, ALU drive/return and result handshake.
interface alu_op_sequencer_if #(
    parameter int DATA_W = 4,
    parameter int RA_W   = 2
);
    logic              ins_valid;
    logic              ins_ready;
    logic [1:0]        ins_op;
    logic [RA_W-1:0]   ins_rd;
    logic [RA_W-1:0]   ins_rs;
    logic [RA_W-1:0]   ins_rt;

    logic              wr_en;
    logic [RA_W-1:0]   wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic [1:0]        alu_sel;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_c;
    logic              alu_carry;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_carry;
    logic [RA_W-1:0]   res_rd;

    // Sequencer side.
    modport slave (
        input  ins_valid, ins_op, ins_rd, ins_rs, ins_rt,
        input  wr_en, wr_addr, wr_data,
        input  alu_c, alu_carry, res_ready,
        output ins_ready, alu_sel, alu_a, alu_b,
        output res_valid, res_data, res_carry, res_rd
    );

    // Instruction source / result consumer / ALU side.
    modport master (
        output ins_valid, ins_op, ins_rd, ins_rs, ins_rt,
        output wr_en, wr_addr, wr_data,
        output alu_c, alu_carry, res_ready,
        input  ins_ready, alu_sel, alu_a, alu_b,
        input  res_valid, res_data, res_carry, res_rd
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issue stage for a combinational ALU: reads operands from a local register file,
// holds ALU inputs for one EXEC cycle, writes back and offers the result (stalls in RESP).
module alu_op_sequencer #(
    parameter int DATA_W = 4,
    parameter int RA_W   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_op_sequencer_if.slave   bus
);
    localparam int NREG = 1 << RA_W;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] rf_q [NREG];
    logic              ins_ready_q;
    logic [1:0]        alu_sel_q;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [RA_W-1:0]   rd_q;
    logic              res_valid_q;
    logic [DATA_W-1:0] res_data_q;
    logic              res_carry_q;
    logic [RA_W-1:0]   res_rd_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.ins_valid) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (bus.res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ins_ready_q <= 1'b1;
            alu_sel_q   <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            rd_q        <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            res_rd_q    <= '0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            ins_ready_q <= (state_d == IDLE);

            if (bus.wr_en) rf_q[bus.wr_addr] <= bus.wr_data;

            case (state_q)
                IDLE: begin
                    // Operands come from the file as it stood before this edge.
                    if (bus.ins_valid) begin
                        alu_sel_q <= bus.ins_op;
                        alu_a_q   <= rf_q[bus.ins_rs];
                        alu_b_q   <= rf_q[bus.ins_rt];
                        rd_q      <= bus.ins_rd;
                    end
                end
                EXEC: begin
                    // Placed after the external write so the ALU writeback wins.
                    rf_q[rd_q]  <= bus.alu_c;
                    res_data_q  <= bus.alu_c;
                    res_carry_q <= bus.alu_carry;
                    res_rd_q    <= rd_q;
                    res_valid_q <= 1'b1;
                end
                RESP: begin
                    if (bus.res_ready) res_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.ins_ready = ins_ready_q;
    assign bus.alu_sel   = alu_sel_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_carry = res_carry_q;
    assign bus.res_rd    = res_rd_q;
endmodule
